tc_acc: RTL and testbench

//  Output accumulator that sits directly downstream of the tensor-core array (TILE_M x TILE_N partial tile per beat).

---
 rtl/tc_acc.sv | 120 ++++++++++++
 tb/tb_tc_acc.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tc_acc.sv
// Tensor-core output accumulator: sums K-slice partial tiles element-wise and
// hands the finished C tile downstream through a single valid/ready holding register.
module tc_acc #(
  parameter int TILE_M     = 4,
  parameter int TILE_N     = 4,
  parameter int DW_IN      = 8,
  parameter int DW_ACC     = 20,
  parameter int MAX_KSTEPS = 16,
  parameter int CW         = $clog2(MAX_KSTEPS + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  input  logic [TILE_M*TILE_N*DW_IN-1:0]   in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [TILE_M*TILE_N*DW_ACC-1:0]  out_data,
  output logic                             out_ovf,
  output logic [CW-1:0]                    out_ksteps,
  output logic                             out_klen_err
);

  localparam int NE = TILE_M * TILE_N;

  function automatic logic signed [DW_ACC-1:0] sign_ext(input logic signed [DW_IN-1:0] x);
    return {{(DW_ACC-DW_IN){x[DW_IN-1]}}, x};
  endfunction

  // Two's-complement wrapping add; MSB of the result carries the signed-overflow flag.
  function automatic logic [DW_ACC:0] add_wrap(input logic signed [DW_ACC-1:0] a,
                                               input logic signed [DW_ACC-1:0] b);
    logic signed [DW_ACC-1:0] s;
    s = a + b;
    return {(a[DW_ACC-1] == b[DW_ACC-1]) && (s[DW_ACC-1] != a[DW_ACC-1]), s};
  endfunction

  logic [NE*DW_ACC-1:0]      acc_p0;
  logic [CW-1:0]             cnt_p0;
  logic                      ovf_p0;

  logic                      vld_p1;
  logic [NE*DW_ACC-1:0]      data_p1;
  logic                      ovf_p1;
  logic [CW-1:0]             ksteps_p1;
  logic                      klen_err_p1;

  logic [NE*DW_ACC-1:0]      sum_flat;
  logic                      beat_ovf;
  logic signed [DW_ACC-1:0]  base;
  logic [DW_ACC:0]           add_r;
  logic [CW-1:0]             cnt_inc;
  logic                      accept;
  logic                      closing;

  assign in_ready = ~vld_p1 | out_ready;
  assign accept   = in_valid & in_ready;
  assign cnt_inc  = cnt_p0 + CW'(1);
  assign closing  = in_last | (cnt_inc == CW'(MAX_KSTEPS));

  // Stage p0: element-wise sum of the incoming slice into the running tile.
  always_comb begin
    sum_flat = '0;
    beat_ovf = 1'b0;
    base     = '0;
    add_r    = '0;
    for (int e = 0; e < NE; e++) begin
      base  = (cnt_p0 == '0) ? '0 : acc_p0[e*DW_ACC +: DW_ACC];
      add_r = add_wrap(base, sign_ext(in_data[e*DW_IN +: DW_IN]));
      sum_flat[e*DW_ACC +: DW_ACC] = add_r[DW_ACC-1:0];
      beat_ovf = beat_ovf | add_r[DW_ACC];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
      ovf_p0 <= 1'b0;
    end else if (accept) begin
      if (closing) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
        ovf_p0 <= 1'b0;
      end else begin
        acc_p0 <= sum_flat;
        cnt_p0 <= cnt_inc;
        ovf_p0 <= ovf_p0 | beat_ovf;
      end
    end
  end

  // Stage p1: output holding register; a closing beat on a drain edge keeps valid high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1      <= 1'b0;
      data_p1     <= '0;
      ovf_p1      <= 1'b0;
      ksteps_p1   <= '0;
      klen_err_p1 <= 1'b0;
    end else begin
      if (vld_p1 && out_ready) vld_p1 <= 1'b0;
      if (accept && closing) begin
        vld_p1      <= 1'b1;
        data_p1     <= sum_flat;
        ovf_p1      <= ovf_p0 | beat_ovf;
        ksteps_p1   <= cnt_inc;
        klen_err_p1 <= ~in_last;
      end
    end
  end

  assign out_valid    = vld_p1;
  assign out_data     = data_p1;
  assign out_ovf      = ovf_p1;
  assign out_ksteps   = ksteps_p1;
  assign out_klen_err = klen_err_p1;

endmodule

// File: tb/tb_tc_acc.sv
// Directed bench for tc_acc: default instance plus a narrow DW_ACC=9 instance for wrap/overflow.
module tb_tc_acc;

  localparam int NE = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              in_valid, in_ready, in_last, out_valid, out_ready, out_ovf, out_klen_err;
  logic [NE*8-1:0]   in_data;
  logic [NE*20-1:0]  out_data;
  logic [CW-1:0]     out_ksteps;

  logic              in_valid9, in_ready9, in_last9, out_valid9, out_ready9, out_ovf9, out_klen_err9;
  logic [NE*8-1:0]   in_data9;
  logic [NE*9-1:0]   out_data9;
  logic [CW-1:0]     out_ksteps9;

  int checks = 0;
  int fails  = 0;

  tc_acc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_ksteps(out_ksteps), .out_klen_err(out_klen_err)
  );

  tc_acc #(.DW_ACC(9)) dut9 (
    .clk(clk), .reset(reset), .in_valid(in_valid9), .in_ready(in_ready9), .in_last(in_last9),
    .in_data(in_data9), .out_valid(out_valid9), .out_ready(out_ready9), .out_data(out_data9),
    .out_ovf(out_ovf9), .out_ksteps(out_ksteps9), .out_klen_err(out_klen_err9)
  );

  function automatic logic [NE*8-1:0] fill_in(input int v);
    logic [NE*8-1:0] r;
    for (int e = 0; e < NE; e++) r[e*8 +: 8] = v[7:0];
    return r;
  endfunction

  function automatic logic [NE*20-1:0] fill20(input int v);
    logic [NE*20-1:0] r;
    for (int e = 0; e < NE; e++) r[e*20 +: 20] = v[19:0];
    return r;
  endfunction

  function automatic logic [NE*9-1:0] fill9(input int v);
    logic [NE*9-1:0] r;
    for (int e = 0; e < NE; e++) r[e*9 +: 9] = v[8:0];
    return r;
  endfunction

  // One accepted-or-offered beat on the default instance; returns 1 ns after the edge.
  task automatic beat(input int v, input logic last);
    in_valid = 1'b1; in_data = fill_in(v); in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic beat9(input int v, input logic last);
    in_valid9 = 1'b1; in_data9 = fill_in(v); in_last9 = last;
    @(posedge clk); #1;
    in_valid9 = 1'b0; in_last9 = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin fails++; $display("FAIL reset_data got %h want 0", out_data); end
    checks++; if ({out_ovf, out_klen_err, out_ksteps} !== 7'd0) begin fails++;
      $display("FAIL reset_flags got ovf=%b err=%b ks=%0d want 0", out_ovf, out_klen_err, out_ksteps); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_accumulate;
    out_ready = 1'b1;
    beat(3, 1'b0);
    beat(3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    beat(3, 1'b0);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL acc_early_valid got %b want 0", out_valid); end
    beat(3, 1'b1);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL acc_valid got %b want 1", out_valid); end
    checks++; if (out_data !== fill20(12)) begin fails++; $display("FAIL acc_data got %h want %h", out_data, fill20(12)); end
    checks++; if (out_ksteps !== 5'd4) begin fails++; $display("FAIL acc_ksteps got %0d want 4", out_ksteps); end
    checks++; if ({out_ovf, out_klen_err} !== 2'b00) begin fails++;
      $display("FAIL acc_flags got ovf=%b err=%b want 0 0", out_ovf, out_klen_err); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL acc_drain got %b want 0", out_valid); end
  endtask

  task automatic test_klen;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) beat(-128, 1'b0);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL klen_early got %b want 0", out_valid); end
    beat(-128, 1'b0);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL klen_valid got %b want 1", out_valid); end
    checks++; if (out_data !== fill20(-2048)) begin fails++; $display("FAIL klen_data got %h want %h", out_data, fill20(-2048)); end
    checks++; if (out_ksteps !== 5'd16) begin fails++; $display("FAIL klen_ksteps got %0d want 16", out_ksteps); end
    checks++; if ({out_klen_err, out_ovf} !== 2'b10) begin fails++;
      $display("FAIL klen_flags got err=%b ovf=%b want 1 0", out_klen_err, out_ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    out_ready9 = 1'b1;
    beat9(127, 1'b0);
    beat9(127, 1'b0);
    beat9(127, 1'b1);
    checks++; if (out_data9 !== fill9(-131)) begin fails++; $display("FAIL wrap_data got %h want %h", out_data9, fill9(-131)); end
    checks++; if ({out_valid9, out_ovf9, out_ksteps9} !== {2'b11, 5'd3}) begin fails++;
      $display("FAIL wrap_flags got v=%b ovf=%b ks=%0d want 1 1 3", out_valid9, out_ovf9, out_ksteps9); end
    beat9(1, 1'b1);
    checks++; if (out_data9 !== fill9(1)) begin fails++; $display("FAIL wrap_next_data got %h want %h", out_data9, fill9(1)); end
    checks++; if ({out_ovf9, out_ksteps9} !== {1'b0, 5'd1}) begin fails++;
      $display("FAIL wrap_next_flags got ovf=%b ks=%0d want 0 1", out_ovf9, out_ksteps9); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    beat(7, 1'b1);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid got %b want 1", out_valid); end
    in_valid = 1'b1; in_data = fill_in(2); in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_data !== fill20(7) || out_ksteps !== 5'd1) begin fails++;
        $display("FAIL bp_hold cyc %0d got %h ks=%0d want %h ks=1", i, out_data, out_ksteps, fill20(7)); end
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== fill20(2)) begin fails++;
      $display("FAIL bp_next got v=%b %h want 1 %h", out_valid, out_data, fill20(2)); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int vals[4] = '{1, -1, 100, -100};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_last = 1'b1; in_data = fill_in(vals[i]);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== fill20(vals[i]) || out_ksteps !== 5'd1) begin fails++;
        $display("FAIL b2b beat %0d got v=%b %h ks=%0d want 1 %h 1", i, out_valid, out_data, out_ksteps, fill20(vals[i])); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    beat(5, 1'b0);
    beat(5, 1'b0);
    #2 reset = 1'b0; #1;
    checks++; if ({out_valid, out_ovf, out_klen_err, out_ksteps} !== 8'd0 || out_data !== '0) begin fails++;
      $display("FAIL rst_mid got v=%b ks=%0d data=%h want all 0", out_valid, out_ksteps, out_data); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    beat(5, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== fill20(5) || out_ksteps !== 5'd1) begin fails++;
      $display("FAIL rst_post got v=%b %h ks=%0d want 1 %h 1", out_valid, out_data, out_ksteps, fill20(5)); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid9 = 1'b0; in_last9 = 1'b0; in_data9 = '0; out_ready9 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    test_accumulate;
    test_klen;
    test_wrap;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
